// File: rtl/irq_sequencer.sv
// irq_sequencer: external-interrupt entry/exit sequencer for the 5-stage MIPS pipeline.
// Detects a rising edge on irq, waits for a valid user-mode instruction in IF/ID,
// then spends one cycle (TAKE) flushing IF/ID and ID/EX, saving that PC as EPC and
// redirecting fetch to VECTOR_ADDR. Further entries are masked until eret; an edge
// seen while masked is remembered and serviced on return.
// Optional macro IRQ_SYNC_EN: insert a SYNC_STAGES-flop synchronizer on irq.
module irq_sequencer #(
   parameter int unsigned     PC_W        = 32,
   parameter logic [PC_W-1:0] VECTOR_ADDR = 32'h80000004,
   parameter int unsigned     SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            irq,
   input  logic            kernel_mode,
   input  logic            id_valid,
   input  logic [PC_W-1:0] id_pc,
   input  logic            eret,
   output logic            flush_if_id,
   output logic            flush_id_ex,
   output logic            pc_redirect,
   output logic [PC_W-1:0] pc_target,
   output logic            epc_we,
   output logic [PC_W-1:0] epc_value,
   output logic            irq_active,
   output logic            irq_pending,
   output logic [7:0]      irq_count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      TAKE    = 2'd2,
      SERVICE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            pend_q, pend_d;
   logic            prev_q;
   logic            s_irq;
   logic            irq_edge;
   logic            take_entry;
   logic [PC_W-1:0] epc_q;
   logic [7:0]      count_q;

`ifdef IRQ_SYNC_EN
   logic [SYNC_STAGES-1:0] sync_q;

   // Shift irq through the synchronizer chain; the last flop is the usable level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], irq};
   end

   assign s_irq = sync_q[SYNC_STAGES-1];
`else
   logic sync_cfg_unused;

   assign sync_cfg_unused = ^SYNC_STAGES;
   assign s_irq           = irq;
`endif

   assign irq_edge   = s_irq & ~prev_q;
   assign take_entry = (state_q == PENDING) && id_valid && !kernel_mode;

   // Edge-detect history, FSM state and the deferred-edge flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q  <= 1'b0;
         state_q <= IDLE;
         pend_q  <= 1'b0;
      end else begin
         prev_q  <= s_irq;
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

   // Capture EPC on entry to TAKE and count interrupts on leaving TAKE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         epc_q   <= '0;
         count_q <= '0;
      end else begin
         if (take_entry)       epc_q   <= id_pc;
         if (state_q == TAKE)  count_q <= count_q + 8'd1;
      end
   end

   // Next-state logic and Moore output decode from the registered state.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      flush_if_id = 1'b0;
      flush_id_ex = 1'b0;
      pc_redirect = 1'b0;
      epc_we      = 1'b0;
      irq_active  = 1'b0;
      irq_pending = 1'b0;
      case (state_q)
         IDLE: begin
            if (irq_edge) state_d = PENDING;
         end
         PENDING: begin
            irq_pending = 1'b1;
            if (take_entry) state_d = TAKE;
         end
         TAKE: begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            pc_redirect = 1'b1;
            epc_we      = 1'b1;
            state_d     = SERVICE;
         end
         SERVICE: begin
            irq_active = 1'b1;
            if (eret) begin
               // An edge coinciding with eret is treated like a remembered one.
               pend_d  = 1'b0;
               state_d = (pend_q || irq_edge) ? PENDING : IDLE;
            end else if (irq_edge) begin
               pend_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pc_target = VECTOR_ADDR;
   assign epc_value = epc_q;
   assign irq_count = count_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Scoreboard bench for irq_sequencer: directed scenarios plus random traffic,
// predicted by a cycle-level behavioural model of interrupt entry/exit.
module tb_irq_sequencer;

   localparam logic [31:0] VEC = 32'h80000004;
`ifdef IRQ_SYNC_EN
   localparam int DLY = 2;
`else
   localparam int DLY = 0;
`endif

   logic        clk, reset, irq, kernel_mode, id_valid, eret;
   logic [31:0] id_pc;
   logic        flush_if_id, flush_id_ex, pc_redirect, epc_we, irq_active, irq_pending;
   logic [31:0] pc_target, epc_value;
   logic [7:0]  irq_count;

   irq_sequencer #(
      .PC_W        (32),
      .VECTOR_ADDR (32'h80000004),
      .SYNC_STAGES (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .irq         (irq),
      .kernel_mode (kernel_mode),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .eret        (eret),
      .flush_if_id (flush_if_id),
      .flush_id_ex (flush_id_ex),
      .pc_redirect (pc_redirect),
      .pc_target   (pc_target),
      .epc_we      (epc_we),
      .epc_value   (epc_value),
      .irq_active  (irq_active),
      .irq_pending (irq_pending),
      .irq_count   (irq_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cmp = 0;
   int errs = 0;
   int cyc = 0;
   int last_take_cyc = -1;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic        pend;
      logic        act;
      logic [3:0]  pulses;
      logic [7:0]  cnt;
      logic [31:0] epc;
   } stat_t;

   typedef struct packed {
      logic [31:0] epc;
      logic [7:0]  cnt;
   } take_t;

   stat_t stat_q[$];
   take_t take_q[$];

   // Behavioural model: where the interrupt is in its life cycle.
   typedef enum int {M_IDLE, M_WAIT, M_ENTER, M_HANDLER} mmode_t;
   mmode_t      m_mode;
   bit          m_prev, m_deferred;
   logic [7:0]  m_count;
   logic [31:0] m_epc;
   bit          dly_q[$];

   bit          d_irq, d_idv, d_km, d_eret;
   logic [31:0] d_pc;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      cmp++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_mode     = M_IDLE;
      m_prev     = 1'b0;
      m_deferred = 1'b0;
      m_count    = 8'd0;
      m_epc      = 32'd0;
      dly_q.delete();
      for (int i = 0; i < DLY; i++) dly_q.push_back(1'b0);
      take_q.delete();
   endtask

   // Advance the model across the coming clock edge given this cycle's inputs.
   task automatic model_update();
      bit eff, rise;
      dly_q.push_back(d_irq);
      eff    = dly_q.pop_front();
      rise   = eff && !m_prev;
      m_prev = eff;
      case (m_mode)
         M_IDLE:  if (rise) m_mode = M_WAIT;
         M_WAIT:  if (d_idv && !d_km) begin
            take_t t;
            t.epc = d_pc;
            t.cnt = m_count;
            take_q.push_back(t);
            m_epc  = d_pc;
            m_mode = M_ENTER;
         end
         M_ENTER: begin
            m_count = m_count + 8'd1;
            m_mode  = M_HANDLER;
         end
         M_HANDLER: begin
            if (d_eret) begin
               m_mode     = (m_deferred || rise) ? M_WAIT : M_IDLE;
               m_deferred = 1'b0;
            end else if (rise) begin
               m_deferred = 1'b1;
            end
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic step_body();
      stat_t s;
      s.pend   = (m_mode == M_WAIT);
      s.act    = (m_mode == M_HANDLER);
      s.pulses = (m_mode == M_ENTER) ? 4'hF : 4'h0;
      s.cnt    = m_count;
      s.epc    = m_epc;
      stat_q.push_back(s);
      irq         = d_irq;
      id_valid    = d_idv;
      kernel_mode = d_km;
      id_pc       = d_pc;
      eret        = d_eret;
      model_update();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      step_body();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic pulse_eret();
      d_eret = 1'b1;
      step();
      d_eret = 1'b0;
   endtask

   task automatic wait_mode(input mmode_t target, input int budget);
      int n = 0;
      while (m_mode != target && n < budget) begin
         step();
         n++;
      end
      if (m_mode != target) begin
         cmp++;
         errs++;
         $display("FAIL wait_mode: budget %0d expired waiting for mode %0d", budget, target);
      end
   endtask

   // Monitor: compare the per-cycle status and every TAKE against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            if (stat_q.size() > 0) begin
               stat_t e, a;
               e = stat_q.pop_front();
               a.pend   = irq_pending;
               a.act    = irq_active;
               a.pulses = {flush_if_id, flush_id_ex, pc_redirect, epc_we};
               a.cnt    = irq_count;
               a.epc    = epc_value;
               check("status", 80'(a), 80'(e));
            end
            if (epc_we) begin
               last_take_cyc = cyc;
               if (take_q.size() == 0) begin
                  cmp++;
                  errs++;
                  $display("FAIL take_unexpected: got TAKE with epc %h, required none", epc_value);
               end else begin
                  take_t t;
                  t = take_q.pop_front();
                  check("take", {epc_value, irq_count, pc_target}, {t.epc, t.cnt, VEC});
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      irq = 1'b0; kernel_mode = 1'b0; id_valid = 1'b0; id_pc = '0; eret = 1'b0;
      d_irq = 1'b0; d_idv = 1'b1; d_km = 1'b0; d_eret = 1'b0; d_pc = 32'h40;
      model_reset();
      #1;
      check("reset_outputs",
            {flush_if_id, flush_id_ex, pc_redirect, epc_we, irq_pending, irq_active, irq_count, epc_value},
            '0);
      #1 reset = 1'b1;

      // Entry: irq rises before posedge 10.
      run(8);
      d_irq = 1'b1;
      step();
      run(5 + DLY);
      check("entry_take_cycle", 80'(last_take_cyc), 80'(11 + DLY));
      pulse_eret();
      d_irq = 1'b0;
      run(3 + DLY);

      // Wait for id_valid.
      d_idv = 1'b0; d_pc = 32'h0000_1000; d_irq = 1'b1;
      run(3 + DLY);
      d_idv = 1'b1;
      wait_mode(M_HANDLER, 10);
      run(2);
      pulse_eret();
      d_irq = 1'b0;
      run(3 + DLY);

      // Kernel mode blocks entry.
      d_km = 1'b1; d_pc = 32'h8000_0100; d_irq = 1'b1;
      run(5 + DLY);
      d_km = 1'b0; d_pc = 32'h0000_2000;
      wait_mode(M_HANDLER, 10);
      pulse_eret();
      d_irq = 1'b0;
      run(3 + DLY);

      // Edge while masked, eret six cycles later, then a second entry.
      d_irq = 1'b1; d_pc = 32'h0000_3000;
      wait_mode(M_HANDLER, 20);
      d_irq = 1'b0;
      run(2);
      d_irq = 1'b1;
      run(1 + DLY);
      run(6);
      pulse_eret();
      wait_mode(M_HANDLER, 20);

      // eret and an edge in the same cycle.
      d_irq = 1'b0;
      run(2 + DLY);
      d_irq = 1'b1;
      run(DLY);
      pulse_eret();
      wait_mode(M_HANDLER, 20);
      pulse_eret();
      d_irq = 1'b0;
      run(3 + DLY);

      // Held level: one entry only.
      d_irq = 1'b1; d_pc = 32'h0000_4000;
      run(20);
      pulse_eret();
      run(5);
      check("held_no_reentry", {irq_pending, irq_active, epc_we}, 3'b000);
      d_irq = 1'b0;
      run(3 + DLY);

      // Reset asserted during TAKE.
      d_irq = 1'b1; d_pc = 32'h0000_5000;
      wait_mode(M_ENTER, 20);
      @(posedge clk);
      #1;
      check("take_before_reset", 80'(epc_we), 80'(1));
      reset = 1'b0;
      #1;
      check("reset_mid_take",
            {flush_if_id, flush_id_ex, pc_redirect, epc_we, irq_pending, irq_active, irq_count, epc_value},
            '0);
      model_reset();
      d_irq = 1'b0;
      irq = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      step_body();
      run(3 + DLY);

      // Count wrap: more than 256 quick entries.
      d_idv = 1'b1; d_km = 1'b0;
      for (int i = 0; i < 260; i++) begin
         d_irq = 1'b1;
         d_pc  = 32'h0001_0000 + 32'(i * 4);
         wait_mode(M_HANDLER, 20);
         d_irq = 1'b0;
         pulse_eret();
      end
      run(3 + DLY);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) d_irq = ~d_irq;
         d_idv  = ($urandom_range(0, 3) != 0);
         d_km   = ($urandom_range(0, 4) == 0);
         d_pc   = $urandom & 32'hFFFF_FFFC;
         d_eret = ($urandom_range(0, 7) == 0);
         step();
      end

      d_irq = 1'b0; d_idv = 1'b1; d_km = 1'b0; d_eret = 1'b0;
      run(4);
      @(negedge clk);
      #1;
      check("takes_drained", 80'(take_q.size()), 80'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Sequences external-interrupt entry and exit for the 5-stage MIPS pipeline, alongside the hazard unit.
- Detects a rising edge on irq and waits for a valid instruction in IF/ID.
- In one cycle it flushes IF/ID and ID/EX, saves that instruction's PC as EPC and redirects the PC to the exception vector.
- Masks further entries until eret; edges seen while masked are remembered and serviced on return.

Parameters:
- PC_W, 32, PC/EPC width.
- VECTOR_ADDR, 32'h80000004, interrupt handler entry address.
- SYNC_STAGES, 2, synchronizer depth on irq (used only with IRQ_SYNC_EN, min 2).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- irq  in  1  external interrupt request, level; only rising edges count.
- kernel_mode  in  1  PC[31] of the instruction in ID; 1 blocks entry.
- id_valid  in  1  IF/ID holds a real instruction (not a flush bubble).
- id_pc  in  PC_W  PC of the instruction in IF/ID.
- eret  in  1  eret decoded in ID, one-cycle pulse.
- flush_if_id  out  1  clear IF/ID; OR-ed with the hazard unit's IF_ID_Clear.
- flush_id_ex  out  1  clear ID/EX; OR-ed with ID_EX_Clear.
- pc_redirect  out  1  PC mux select for pc_target.
- pc_target  out  PC_W  constant VECTOR_ADDR.
- epc_we  out  1  EPC register write enable.
- epc_value  out  PC_W  id_pc captured in TAKE.
- irq_active  out  1  handler running (SERVICE state).
- irq_pending  out  1  edge latched, not yet taken.
- irq_count  out  8  number of interrupts taken, wraps 255->0.

Behaviour:
- Reset values: state IDLE, all pulse outputs 0, epc_value 0, irq_count 0, pend 0, edge-detect flop 0, sync flops 0.
- s_irq is irq after the synchronizer, or irq directly when no synchronizer is compiled in.
- Edge detection:
  - prev <= s_irq every cycle.
  - edge = s_irq & ~prev.
  - A level held high produces exactly one edge.
- FSM states: IDLE, PENDING, TAKE, SERVICE (2-bit encoding).
- IDLE:
  - edge -> PENDING at the next posedge.
- PENDING:
  - irq_pending=1.
  - If id_valid & ~kernel_mode in the current cycle -> TAKE at the next posedge; otherwise stay.
  - Wait is unbounded; an interrupt is never dropped.
- TAKE (exactly one cycle):
  - flush_if_id=1, flush_id_ex=1, pc_redirect=1, epc_we=1.
  - epc_value = id_pc registered on entry to TAKE, i.e. the id_pc from the last PENDING cycle.
  - irq_count increments on exit.
  - Next state is SERVICE unconditionally.
  - The flush takes priority over a concurrent hazard-unit stall. The stalled instruction is flushed and re-executed from EPC.
- SERVICE:
  - irq_active=1.
  - An edge sets pend.
  - eret -> IDLE if pend=0 and no edge this cycle; otherwise -> PENDING with pend cleared.
  - eret and an edge in the same cycle -> PENDING.
- Edges arriving in PENDING or TAKE are merged; no second entry results.
- Outputs in TAKE and SERVICE are Moore outputs decoded from registered state, so there are no combinational paths from inputs to outputs.
- eret outside SERVICE is ignored.
- reset asserted mid-TAKE: pulses drop immediately, EPC is not written, irq_count is unchanged.
- Latency without sync, from irq rising before posedge N with id_valid=1 and kernel_mode=0:
  - PENDING from N.
  - TAKE from N+1.
  - SERVICE from N+2.
- With sync: add SYNC_STAGES cycles.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: irq passes through a SYNC_STAGES-flop synchronizer, all flops reset to 0; entry latency grows by SYNC_STAGES cycles.
- Undefined: irq is used directly and must already be synchronous to clk; no synchronizer flops exist.

Test Plan:
- Entry: sync off, id_valid=1, kernel_mode=0, id_pc=0x00000040, irq rises before posedge 10.
  - Required: TAKE during cycle 11 with all four pulses high for one cycle.
  - Required: epc_value=0x40, pc_target=0x80000004, irq_count=1, irq_active=1 from cycle 12.
- Wait: irq edge with id_valid=0 for 3 cycles, then id_valid=1.
  - Required: irq_pending=1 for 4 cycles; TAKE on the cycle after id_valid rises.
- Kernel block: kernel_mode=1 for 5 cycles after an edge.
  - Required: no pulses during those cycles; TAKE one cycle after kernel_mode falls.
- Masked edge: second irq edge in SERVICE, eret 6 cycles later.
  - Required: state goes to PENDING, then a second TAKE; irq_count=2.
  - Also cover eret and an edge in the same cycle: required next state PENDING.
- Held level: irq held high for 20 cycles.
  - Required: exactly one TAKE; after eret, state IDLE with no re-entry.
- Reset mid-TAKE: reset=0 during the TAKE cycle.
  - Required: all outputs 0 immediately, epc_value stays 0, irq_count stays 0.
  - Required: state is IDLE after reset releases.
- With IRQ_SYNC_EN and SYNC_STAGES=2: repeat the entry scenario.
  - Required: TAKE during cycle 13.
